// File: rtl/fifo_nibble_packer.sv
// Pops 4-bit nibbles from a registered-output sync FIFO and packs pairs into 8-bit words.
// Define PACKER_FLUSH_EN to flush a lone nibble as a partial word after 15 empty cycles.
module fifo_nibble_packer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fifo_empty,
  input  logic [3:0] fifo_rd,
  output logic       fifo_rd_en,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_partial,
  output logic [7:0] word_cnt,
  output logic [2:0] state_dbg
);

  // Output handshake: a word moves when out_valid && out_ready at a rising edge;
  // out_valid, out_data and out_partial hold steady until that edge.
  typedef enum logic [2:0] {IDLE, LO_WAIT, HI, HI_WAIT, HOLD} state_t;

  state_t state_q, state_d;
  logic   rd_req;
  logic   cap_lo;
  logic   cap_hi;
  logic   xfer;

`ifdef PACKER_FLUSH_EN
  logic [3:0] wait_cnt;
  logic       flush;
  logic       partial_q;
`endif

  always_comb begin
    state_d = state_q;
    rd_req  = 1'b0;
    cap_lo  = 1'b0;
    cap_hi  = 1'b0;
    xfer    = 1'b0;
`ifdef PACKER_FLUSH_EN
    flush   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        rd_req = !fifo_empty;
        if (rd_req) state_d = LO_WAIT;
      end
      LO_WAIT: begin
        cap_lo  = 1'b1;
        state_d = HI;
      end
      HI: begin
        rd_req = !fifo_empty;
        if (rd_req) begin
          state_d = HI_WAIT;
        end
`ifdef PACKER_FLUSH_EN
        // wait_cnt already holds 14 empty cycles, so this is the 15th
        else if (wait_cnt == 4'd14) begin
          flush   = 1'b1;
          state_d = HOLD;
        end
`endif
      end
      HI_WAIT: begin
        cap_hi  = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          xfer    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gated by rst_n so the pop request drops the instant reset asserts.
  assign fifo_rd_en = rd_req && rst_n;
  assign state_dbg  = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      word_cnt  <= 8'h00;
    end else begin
      state_q <= state_d;
      if (cap_lo) out_data[3:0] <= fifo_rd;
      if (cap_hi) begin
        out_data[7:4] <= fifo_rd;
        out_valid     <= 1'b1;
      end
`ifdef PACKER_FLUSH_EN
      if (flush) begin
        out_data[7:4] <= 4'h0;
        out_valid     <= 1'b1;
      end
`endif
      if (xfer) begin
        out_valid <= 1'b0;
        word_cnt  <= word_cnt + 8'd1;
      end
    end
  end

`ifdef PACKER_FLUSH_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= 4'd0;
      partial_q <= 1'b0;
    end else begin
      if (cap_lo) begin
        wait_cnt <= 4'd0;
      end else if (state_q == HI && fifo_empty) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
      if (cap_hi || xfer) partial_q <= 1'b0;
      else if (flush)     partial_q <= 1'b1;
    end
  end

  assign out_partial = partial_q;
`else
  assign out_partial = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_nibble_packer.sv
// Bench for fifo_nibble_packer: queue-based FIFO, nibble-count reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fifo_nibble_packer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fifo_empty;
  logic [3:0] fifo_rd = 4'h0;
  logic       fifo_rd_en;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_partial;
  logic [7:0] word_cnt;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  fifo_nibble_packer dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
    .fifo_rd_en(fifo_rd_en), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_partial(out_partial), .word_cnt(word_cnt),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- FIFO model ----------------
  logic [3:0] fifo_q[$];
  int push_total = 0;
  int pop_total  = 0;
  assign fifo_empty = (push_total == pop_total);

  always @(posedge clk) begin
    if (fifo_rd_en && fifo_q.size() > 0) begin
      fifo_rd   <= fifo_q.pop_front();
      pop_total <= pop_total + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks how many nibbles of the current word have landed, whether a pop is in flight,
  // and whether a finished word is waiting for the consumer.
  logic       m_valid, m_partial, m_pending;
  logic [7:0] m_data, m_cnt;
  int         m_have, m_run;
  logic [8:0] exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_partial = 0; m_pending = 0;
      m_data = 0; m_cnt = 0; m_have = 0; m_run = 0;
      exp_q.delete();
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid = 0; m_partial = 0; m_cnt = m_cnt + 8'd1;
      end
    end else if (m_pending) begin
      m_pending = 0;
      if (m_have == 0) begin
        m_data[3:0] = fifo_rd; m_have = 1; m_run = 0;
      end else begin
        m_data[7:4] = fifo_rd; m_have = 0; m_valid = 1; m_partial = 0;
        exp_q.push_back({1'b0, m_data});
      end
    end else if (!fifo_empty) begin
      m_pending = 1;
    end else if (m_have == 1) begin
      m_run++;
`ifdef PACKER_FLUSH_EN
      if (m_run == 15) begin
        m_data[7:4] = 4'h0; m_have = 0; m_valid = 1; m_partial = 1;
        exp_q.push_back({1'b1, m_data});
      end
`endif
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("rd_en", fifo_rd_en, rst_n && !m_valid && !m_pending && !fifo_empty);
    chk("valid", out_valid, m_valid);
    chk("data", out_data, m_data);
    chk("partial", out_partial, m_partial);
    chk("word_cnt", word_cnt, m_cnt);
  end

  // ---------------- scoreboard on transfers ----------------
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      chk("sb_word_present", exp_q.size(), 1);
      if (exp_q.size() > 0) chk("sb_word", {out_partial, out_data}, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] v);
    fifo_q.push_back(v);
    push_total++;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!out_valid && n < max) begin
      cyc();
      n++;
    end
    chk("wait_valid", out_valid, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int quiet;
    quiet = 0;
    rst_n = 0;
    out_ready = 0;
    repeat (3) cyc();
    chk("rst_data", out_data, 8'h00);
    chk("rst_valid", out_valid, 0);
    chk("rst_partial", out_partial, 0);
    chk("rst_cnt", word_cnt, 8'h00);
    chk("rst_rd_en", fifo_rd_en, 0);
    rst_n = 1;

    // 0xA then 0x5, consumer always ready
    out_ready = 1;
    push(4'hA); push(4'h5);
    wait_valid(20, n);
    chk("latency", n, 4);
    chk("w1_data", out_data, 8'h5A);
    chk("w1_partial", out_partial, 0);
    cyc();
    chk("w1_valid_drop", out_valid, 0);
    chk("w1_cnt", word_cnt, 8'd1);

    // back-pressure for 10 cycles with more data waiting in the FIFO
    out_ready = 0;
    push(4'hA); push(4'h5);
    wait_valid(20, n);
    push(4'h9); push(4'h6);
    repeat (10) begin
      cyc();
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, 8'h5A);
      chk("hold_rd_en", fifo_rd_en, 0);
      chk("hold_cnt", word_cnt, 8'd1);
    end
    out_ready = 1;
    cyc();
    chk("hold_release_cnt", word_cnt, 8'd2);
    chk("hold_release_valid", out_valid, 0);
    wait_valid(20, n);
    chk("after_hold_data", out_data, 8'h69);
    cyc();

    // lone nibble 0x3
    push(4'h3);
`ifdef PACKER_FLUSH_EN
    wait_valid(40, n);
    chk("flush_latency", n, 17);
    chk("flush_data", out_data, 8'h03);
    chk("flush_partial", out_partial, 1);
    cyc();
    chk("flush_drop", out_valid, 0);
`else
    repeat (30) begin
      cyc();
      chk("no_flush_valid", out_valid, 0);
    end
    push(4'h4);
    wait_valid(20, n);
    chk("late_hi_data", out_data, 8'h43);
    chk("late_hi_partial", out_partial, 0);
    cyc();
`endif

    // reset while waiting for the high nibble after capturing 0x7
    push(4'h7);
    repeat (2) cyc();
    chk("lo_capture", out_data[3:0], 4'h7);
    rst_n = 0;
    push(4'h1); push(4'h2);
    #1;
    chk("rst2_data", out_data, 8'h00);
    chk("rst2_valid", out_valid, 0);
    chk("rst2_partial", out_partial, 0);
    chk("rst2_cnt", word_cnt, 8'h00);
    chk("rst2_rd_en", fifo_rd_en, 0);
    cyc(); cyc();
    rst_n = 1;
    wait_valid(20, n);
    chk("post_rst_data", out_data, 8'h21);
    cyc();

    // FIFO empty throughout
    repeat (20) begin
      cyc();
      chk("idle_rd_en", fifo_rd_en, 0);
      chk("idle_valid", out_valid, 0);
    end

    // 256 back-to-back words: counter wraps to zero
    rst_n = 0;
    cyc();
    rst_n = 1;
    for (int i = 0; i < 512; i++) push(4'($urandom_range(0, 15)));
    repeat (1275) cyc();
    chk("cnt_255", word_cnt, 8'd255);
    repeat (5) cyc();
    chk("cnt_wrap", word_cnt, 8'd0);

    // randomized traffic, stalls, starvation gaps and reset pulses
    repeat (3000) begin
      cyc();
      out_ready = ($urandom_range(0, 9) < 7);
      if (quiet > 0) begin
        quiet--;
      end else if ($urandom_range(0, 99) == 0) begin
        quiet = $urandom_range(16, 30);
      end else if ($urandom_range(0, 2) == 0) begin
        push(4'($urandom_range(0, 15)));
      end
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 0;
        #2;
        rst_n = 1;
      end
    end
    out_ready = 1;
    repeat (40) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
